// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with bounded hold time and registered one-hot grant
module rr_arbiter #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           expired
);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  typedef enum logic {IDLE, OWNED} state_t;
  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n, id_n, win;
  logic [HW-1:0]  hold_cnt, hold_n;
  logic [N-1:0]   req_s, grant_n;
  logic           hit, rel, tmo, exp_n;
  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'(v % N);
  endfunction
  // search from ptr; ptr is always owner+1, so a timeout search naturally visits the owner last
  always_comb begin
    rel = state == OWNED && !req[grant_id];
    tmo = state == OWNED && !rel && hold_cnt == HW'(MAX_HOLD - 1);
    req_s = rel ? req & ~(N'(1) << grant_id) : req;
    win = '0;
    hit = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req_s[wrap(int'(ptr) + k)]) begin
        win = wrap(int'(ptr) + k);
        hit = 1'b1;
      end
  end
  // next state: rearbitrate when idle, on release or on timeout; otherwise keep owner and count
  always_comb begin
    state_n = state;
    id_n = grant_id;
    ptr_n = ptr;
    hold_n = hold_cnt + 1'b1;
    exp_n = 1'b0;
    if (state == IDLE || rel || tmo) begin
      state_n = hit ? OWNED : IDLE;
      id_n = hit ? win : '0;
      ptr_n = hit ? wrap(int'(win) + 1) : ptr;
      hold_n = '0;
      exp_n = tmo && win != grant_id;
    end
    grant_n = state_n == OWNED ? N'(1) << id_n : '0;
  end
  // all outputs come straight from flops
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      grant <= '0;
      grant_id <= '0;
      grant_valid <= 1'b0;
      expired <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      hold_cnt <= hold_n;
      grant <= grant_n;
      grant_id <= id_n;
      grant_valid <= state_n == OWNED;
      expired <= exp_n;
    end
endmodule
